maxpool_nch_2d_stream: RTL and testbench

Parametrised streaming 2-D max-pooling stage that replaces the fixed 12-channel, 3×3-kernel pooling block in the CNN datapath. It accepts one pixel per `valid_in` cycle in raster order, with all channels in parallel on a packed bus. It emits one pooled pixel per K×K window at the configured stride. Kernel size, channel count and arithmetic mode (signed compare, optional ReLU) are configurable, and a frame-end flag marks the last output of each frame.

---
 rtl/maxpool_nch_2d_stream_pkg.sv | 42 ++++
 rtl/maxpool_line_buffer.sv | 65 ++++++
 rtl/maxpool_nch_2d_stream.sv | 163 ++++++++++++++++
 tb/tb_maxpool_nch_2d_stream.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_nch_2d_stream_pkg.sv
// rtl/maxpool_nch_2d_stream_pkg.sv - shared constants and helpers for the streaming max-pool stage
// Purpose: kernel limit, output-dimension arithmetic and the signed/unsigned
//          greater-than helper shared by the pooling top level and its line buffer.
package maxpool_nch_2d_stream_pkg;

    localparam int MP_MAX_KERNEL = 5;
    // Widest channel sample the compare helper can handle.
    localparam int MP_MAX_DW = 64;

    // Number of pooled outputs along one axis; trailing samples that do not
    // fill a whole window are dropped.
    function automatic int mp_out_dim(input int dim, input int k, input int stride);
        return (dim - k) / stride + 1;
    endfunction

    // Kernel clamped into the supported range so array bounds stay sane even
    // under a bad parameter override.
    function automatic int mp_kernel_clamp(input int k);
        if (k < 2)
            return 2;
        if (k > MP_MAX_KERNEL)
            return MP_MAX_KERNEL;
        return k;
    endfunction

    // a > b for 'width'-bit samples held zero-extended in the low bits.
    // Shifting both operands so the sample MSB lands on bit 63 makes a single
    // 64-bit signed/unsigned compare correct for any width.
    function automatic logic mp_greater(input logic [MP_MAX_DW-1:0] a,
                                        input logic [MP_MAX_DW-1:0] b,
                                        input logic                 is_signed,
                                        input int                   width);
        logic [MP_MAX_DW-1:0] aa;
        logic [MP_MAX_DW-1:0] bb;
        aa = a << (MP_MAX_DW - width);
        bb = b << (MP_MAX_DW - width);
        if (is_signed)
            return $signed(aa) > $signed(bb);
        return aa > bb;
    endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// rtl/maxpool_line_buffer.sv - K-1 row memories feeding the vertical taps of the pooling window
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   accept data at wr_col (one per accepted pixel)
//   wr_col   in   current column
//   wr_data  in   current pixel, all channels packed
//   taps     out  tap j (bits [j*Width +: Width]) = pixel j+1 rows above at wr_col
//   tap_max  out  per-channel max over the K-1 taps
module maxpool_line_buffer
    import maxpool_nch_2d_stream_pkg::*;
#(
    parameter int IMG_Width = 3,
    parameter int Datawidth = 32,
    parameter int Channel   = 12,
    parameter int Kernel    = 3,
    parameter int Signed    = 1,
    parameter int COL_W     = 2
) (
    input  logic                                          clk,
    input  logic                                          wr_en,
    input  logic [COL_W-1:0]                              wr_col,
    input  logic [Channel*Datawidth-1:0]                  wr_data,
    output logic [(mp_kernel_clamp(Kernel)-1)*Channel*Datawidth-1:0] taps,
    output logic [Channel*Datawidth-1:0]                  tap_max
);

    localparam int TAPS  = mp_kernel_clamp(Kernel) - 1;
    localparam int WIDTH = Channel * Datawidth;

    logic [WIDTH-1:0] mem [TAPS][IMG_Width];

    // Rows cascade downwards within a column: the row written now becomes
    // tap 0, and every older row moves one tap further away.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[0][wr_col] <= wr_data;
            for (int j = 1; j < TAPS; j++)
                mem[j][wr_col] <= mem[j-1][wr_col];
        end
    end

    logic [MP_MAX_DW-1:0] best64;
    logic [MP_MAX_DW-1:0] cand64;

    always_comb begin
        taps    = '0;
        tap_max = '0;
        best64  = '0;
        cand64  = '0;
        for (int j = 0; j < TAPS; j++)
            taps[j*WIDTH +: WIDTH] = mem[j][wr_col];
        for (int ch = 0; ch < Channel; ch++) begin
            best64 = '0;
            best64[Datawidth-1:0] = mem[0][wr_col][ch*Datawidth +: Datawidth];
            for (int j = 1; j < TAPS; j++) begin
                cand64 = '0;
                cand64[Datawidth-1:0] = mem[j][wr_col][ch*Datawidth +: Datawidth];
                if (mp_greater(cand64, best64, Signed != 0, Datawidth))
                    best64 = cand64;
            end
            tap_max[ch*Datawidth +: Datawidth] = best64[Datawidth-1:0];
        end
    end

endmodule

// File: rtl/maxpool_nch_2d_stream.sv
// rtl/maxpool_nch_2d_stream.sv - streaming multi-channel 2-D max-pooling stage
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   valid_in   in   data_in holds a valid pixel (raster order)
//   data_in    in   channel c in bits [c*Datawidth +: Datawidth]
//   valid_out  out  one-cycle pulse per completed window
//   data_out   out  pooled pixel, same packing as data_in
//   last_out   out  high with valid_out on the final window of a frame
module maxpool_nch_2d_stream
    import maxpool_nch_2d_stream_pkg::*;
#(
    parameter int IMG_Width  = 3,
    parameter int IMG_Height = 3,
    parameter int Datawidth  = 32,
    parameter int Channel    = 12,
    parameter int Kernel     = 3,
    parameter int Stride     = 2,
    parameter int Signed     = 1,
    parameter int ReLU       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [Channel*Datawidth-1:0] data_in,
    output logic                         valid_out,
    output logic [Channel*Datawidth-1:0] data_out,
    output logic                         last_out
);

    localparam int K        = mp_kernel_clamp(Kernel);
    localparam int KM1      = K - 1;
    localparam int CW       = Channel * Datawidth;
    localparam int OH       = mp_out_dim(IMG_Height, K, Stride);
    localparam int OW       = mp_out_dim(IMG_Width, K, Stride);
    // Raster position of the pixel that completes the final window.
    localparam int LAST_ROW = (OH - 1) * Stride + KM1;
    localparam int LAST_COL = (OW - 1) * Stride + KM1;
    localparam int COL_W    = (IMG_Width > 1) ? $clog2(IMG_Width) : 1;
    localparam int ROW_W    = (IMG_Height > 1) ? $clog2(IMG_Height) : 1;

    function automatic logic gt(input logic [Datawidth-1:0] a, input logic [Datawidth-1:0] b);
        logic [MP_MAX_DW-1:0] a64;
        logic [MP_MAX_DW-1:0] b64;
        a64 = '0;
        b64 = '0;
        a64[Datawidth-1:0] = a;
        b64[Datawidth-1:0] = b;
        return mp_greater(a64, b64, Signed != 0, Datawidth);
    endfunction

    // ---------------------------------------------------------------- counters
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col == COL_W'(IMG_Width - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(IMG_Height - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- line buffer
    logic [KM1*CW-1:0] lb_taps;
    logic [CW-1:0]     lb_tap_max;

    maxpool_line_buffer #(
        .IMG_Width (IMG_Width),
        .Datawidth (Datawidth),
        .Channel   (Channel),
        .Kernel    (K),
        .Signed    (Signed),
        .COL_W     (COL_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (valid_in),
        .wr_col  (col),
        .wr_data (data_in),
        .taps    (lb_taps),
        .tap_max (lb_tap_max)
    );

    // ------------------------------------------------------- window datapath
    // Max is associative, so each column is first reduced vertically and only
    // the K-1 previous column maxima are kept as the horizontal window.
    logic [CW-1:0]        col_max;
    logic [CW-1:0]        win_max;
    logic [CW-1:0]        hist [KM1];
    logic [Datawidth-1:0] best;
    logic [Datawidth-1:0] cand;

    always_comb begin
        col_max = '0;
        win_max = '0;
        best    = '0;
        cand    = '0;
        for (int ch = 0; ch < Channel; ch++) begin
            best = data_in[ch*Datawidth +: Datawidth];
            cand = lb_tap_max[ch*Datawidth +: Datawidth];
            if (gt(cand, best))
                best = cand;
            col_max[ch*Datawidth +: Datawidth] = best;
            for (int j = 0; j < KM1; j++) begin
                cand = hist[j][ch*Datawidth +: Datawidth];
                if (gt(cand, best))
                    best = cand;
            end
            if (Signed != 0 && ReLU != 0 && best[Datawidth-1])
                best = '0;
            win_max[ch*Datawidth +: Datawidth] = best;
        end
    end

    // History entries are only consumed once the current row has refilled
    // them (col >= K-1), so they need no reset.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            hist[0] <= col_max;
            for (int j = 1; j < KM1; j++)
                hist[j] <= hist[j-1];
        end
    end

    // A window is done when the current pixel is its bottom-right corner and
    // its top-left corner sits on the stride grid. The bottom/right fit check
    // is implicit because row/col never exceed the image.
    int   row_i;
    int   col_i;
    logic win_done;
    logic win_last;

    always_comb begin
        row_i    = int'(row);
        col_i    = int'(col);
        win_done = valid_in
                   && (row_i >= KM1) && (col_i >= KM1)
                   && (((row_i - KM1) % Stride) == 0)
                   && (((col_i - KM1) % Stride) == 0);
        win_last = (row_i == LAST_ROW) && (col_i == LAST_COL);
    end

    // ---------------------------------------------------------- output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= win_done;
            last_out  <= win_done && win_last;
            if (win_done)
                data_out <= win_max;
        end
    end

endmodule

// File: tb/tb_maxpool_nch_2d_stream.sv
// tb/tb_maxpool_nch_2d_stream.sv - scoreboard bench for the streaming max-pool stage
module tb_maxpool_nch_2d_stream;

    localparam int NDUT = 3;
    localparam int CFG_W  [NDUT] = '{4, 5, 8};
    localparam int CFG_H  [NDUT] = '{4, 6, 6};
    localparam int CFG_K  [NDUT] = '{2, 3, 3};
    localparam int CFG_S  [NDUT] = '{2, 1, 2};
    localparam int CFG_C  [NDUT] = '{2, 3, 2};
    localparam int CFG_DW [NDUT] = '{8, 8, 12};
    localparam int CFG_SG [NDUT] = '{0, 1, 1};
    localparam int CFG_RL [NDUT] = '{0, 0, 1};

    typedef struct {
        int          dut;
        logic [63:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic        last;
    } win_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin = 1'b0;
    int          sel = 0;
    logic [63:0] din = '0;
    logic [2:0]  vout;
    logic [2:0]  lout;
    logic [15:0] dout_a;
    logic [23:0] dout_b;
    logic [23:0] dout_c;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    exp_t        exp_q[$];
    win_t        win_q[$];
    logic [63:0] pix[$];
    exp_t        mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool_nch_2d_stream #(
        .IMG_Width(CFG_W[0]), .IMG_Height(CFG_H[0]), .Datawidth(CFG_DW[0]), .Channel(CFG_C[0]),
        .Kernel(CFG_K[0]), .Stride(CFG_S[0]), .Signed(CFG_SG[0]), .ReLU(CFG_RL[0])
    ) dut_a (
        .clk(clk), .rst(rst), .valid_in(vin && sel == 0), .data_in(din[15:0]),
        .valid_out(vout[0]), .data_out(dout_a), .last_out(lout[0])
    );

    maxpool_nch_2d_stream #(
        .IMG_Width(CFG_W[1]), .IMG_Height(CFG_H[1]), .Datawidth(CFG_DW[1]), .Channel(CFG_C[1]),
        .Kernel(CFG_K[1]), .Stride(CFG_S[1]), .Signed(CFG_SG[1]), .ReLU(CFG_RL[1])
    ) dut_b (
        .clk(clk), .rst(rst), .valid_in(vin && sel == 1), .data_in(din[23:0]),
        .valid_out(vout[1]), .data_out(dout_b), .last_out(lout[1])
    );

    maxpool_nch_2d_stream #(
        .IMG_Width(CFG_W[2]), .IMG_Height(CFG_H[2]), .Datawidth(CFG_DW[2]), .Channel(CFG_C[2]),
        .Kernel(CFG_K[2]), .Stride(CFG_S[2]), .Signed(CFG_SG[2]), .ReLU(CFG_RL[2])
    ) dut_c (
        .clk(clk), .rst(rst), .valid_in(vin && sel == 2), .data_in(din[23:0]),
        .valid_out(vout[2]), .data_out(dout_c), .last_out(lout[2])
    );

    function automatic logic [63:0] dout_of(input int d);
        logic [63:0] r;
        r = '0;
        case (d)
            0:       r[15:0] = dout_a;
            1:       r[23:0] = dout_b;
            default: r[23:0] = dout_c;
        endcase
        return r;
    endfunction

    // Channel sample as a plain integer, honouring the configured signedness.
    function automatic longint ch_val(input logic [63:0] w, input int ch, input int dw, input int sg);
        longint v;
        v = 0;
        for (int b = 0; b < dw; b++)
            v[b] = w[ch*dw + b];
        if (sg != 0 && v[dw-1])
            v = v - (longint'(1) << dw);
        return v;
    endfunction

    // Frame pixels: mode 0 = base+index on every channel, mode 1 = random.
    task automatic gen_frame(input int d, input int mode, input int base);
        logic [63:0] w;
        int          v;
        pix.delete();
        for (int p = 0; p < CFG_W[d] * CFG_H[d]; p++) begin
            w = '0;
            for (int ch = 0; ch < CFG_C[d]; ch++) begin
                v = (mode == 1) ? int'($urandom) : base + p;
                for (int b = 0; b < CFG_DW[d]; b++)
                    w[ch*CFG_DW[d] + b] = v[b];
            end
            pix.push_back(w);
        end
    endtask

    // Reference: enumerate every window on the stride grid that fits, take the
    // plain integer max over its KxK pixels, and note the raster index of the
    // pixel that completes it.
    task automatic build_model(input int d);
        int          w, h, k, s, dw;
        longint      m, v;
        win_t        wn;
        w = CFG_W[d]; h = CFG_H[d]; k = CFG_K[d]; s = CFG_S[d]; dw = CFG_DW[d];
        win_q.delete();
        for (int r = 0; r + k <= h; r += s) begin
            for (int c = 0; c + k <= w; c += s) begin
                wn.idx  = (r + k - 1) * w + (c + k - 1);
                wn.last = (r + s + k > h) && (c + s + k > w);
                wn.data = '0;
                for (int ch = 0; ch < CFG_C[d]; ch++) begin
                    m = ch_val(pix[r*w + c], ch, dw, CFG_SG[d]);
                    for (int dr = 0; dr < k; dr++)
                        for (int dc = 0; dc < k; dc++) begin
                            v = ch_val(pix[(r+dr)*w + c + dc], ch, dw, CFG_SG[d]);
                            if (v > m) m = v;
                        end
                    if (CFG_RL[d] != 0 && m < 0) m = 0;
                    for (int b = 0; b < dw; b++)
                        wn.data[ch*dw + b] = m[b];
                end
                win_q.push_back(wn);
            end
        end
    endtask

    // Drives the first npix pixels of pix[] into DUT d with random idle cycles.
    task automatic drive_frame(input int d, input int npix, input int gap_pct);
        win_t wn;
        exp_t e;
        build_model(d);
        for (int p = 0; p < npix; p++) begin
            while ($urandom_range(99) < gap_pct) begin
                vin = 1'b0;
                @(posedge clk); #1;
            end
            sel = d;
            din = pix[p];
            vin = 1'b1;
            if (win_q.size() > 0 && win_q[0].idx == p) begin
                wn = win_q.pop_front();
                e.dut  = d;
                e.data = wn.data;
                e.last = wn.last;
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        vin = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            n_vec++;
            if (vout[d] !== 1'b0 || lout[d] !== 1'b0 || dout_of(d) !== 64'd0) begin
                n_bad++;
                $display("FAIL %s dut=%0d got valid=%b last=%b data=%h required 0 0 0",
                         tag, d, vout[d], lout[d], dout_of(d));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < NDUT; d++) begin
                if (vout[d]) begin
                    n_vec++;
                    if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                        n_bad++;
                        $display("FAIL unexpected_output dut=%0d data=%h last=%b cyc=%0d required no output",
                                 d, dout_of(d), lout[d], cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (dout_of(d) !== mon_e.data || lout[d] !== mon_e.last || cyc != mon_e.cyc) begin
                            n_bad++;
                            $display("FAIL pooled_output dut=%0d got data=%h last=%b cyc=%0d required data=%h last=%b cyc=%0d",
                                     d, dout_of(d), lout[d], cyc, mon_e.data, mon_e.last, mon_e.cyc);
                        end
                    end
                end else if (lout[d]) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL last_without_valid dut=%0d cyc=%0d got last=1 required 0", d, cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;

        // Sequential 4x4 frame, continuous then gapped.
        gen_frame(0, 0, 1);
        drive_frame(0, 16, 0);
        drive_frame(0, 16, 50);

        // Partial frame discarded by an asynchronous reset, then a clean frame.
        drive_frame(0, 5, 0);
        rst = 1'b1;
        #1;
        check_reset("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        drive_frame(0, 16, 0);

        // Back-to-back frames with no idle cycle between them.
        gen_frame(0, 0, 101);
        drive_frame(0, 16, 0);
        gen_frame(0, 0, 1);
        drive_frame(0, 16, 0);
        gen_frame(0, 0, 101);
        drive_frame(0, 16, 0);

        for (int i = 0; i < 4; i++) begin
            gen_frame(0, 1, 0);
            drive_frame(0, 16, (i % 2) * 40);
        end

        // Signed, stride 1, non-square: all-negative ramp, then random.
        gen_frame(1, 0, -30);
        drive_frame(1, 30, 0);
        for (int i = 0; i < 4; i++) begin
            gen_frame(1, 1, 0);
            drive_frame(1, 30, (i % 2) * 30);
        end

        // Signed with ReLU, trailing row and column dropped.
        gen_frame(2, 0, -48);
        drive_frame(2, 48, 0);
        for (int i = 0; i < 4; i++) begin
            gen_frame(2, 1, 0);
            drive_frame(2, 48, (i % 2) * 30);
        end

        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_outputs got %0d outstanding required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
